// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: IR field layout,
// opcode constants, ALU_select codes, FSM state encoding and decode class.
package control_sequencer_pkg;

  localparam int IR_W      = 32;
  localparam int REG_IDX_W = 4;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OPC_ALU_LO = 5'b00011;
  localparam logic [4:0] OPC_ALU_HI = 5'b01010;
  localparam logic [4:0] OPC_NOP    = 5'b11010;
  localparam logic [4:0] OPC_HALT   = 5'b11011;

  // ALU_select carries the opcode itself during T4; zero means no operation
  localparam logic [4:0] ALU_SEL_NONE = 5'b00000;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_HALT  = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  typedef struct packed {
    logic is_alu;
    logic is_nop;
    logic is_halt;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/control_sequencer_ir_decoder.sv
// ir_decoder: classifies the IR opcode and expands ra/rb/rc into register
// one-hots.
module ir_decoder
  import control_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [IR_W-1:0]     IR,
  output op_class_t           cls,
  output logic [4:0]          opc,
  output logic [NUM_REGS-1:0] ra_oh,
  output logic [NUM_REGS-1:0] rb_oh,
  output logic [NUM_REGS-1:0] rc_oh
);

  logic [REG_IDX_W-1:0] ra, rb, rc;
  logic                 unused_ir;

  assign opc = IR[OPC_MSB:OPC_LSB];
  assign ra  = IR[RA_MSB:RA_LSB];
  assign rb  = IR[RB_MSB:RB_LSB];
  assign rc  = IR[RC_MSB:RC_LSB];
  assign unused_ir = ^IR[RC_LSB-1:0];

  assign cls.is_alu     = (opc >= OPC_ALU_LO) && (opc <= OPC_ALU_HI);
  assign cls.is_nop     = (opc == OPC_NOP);
  assign cls.is_halt    = (opc == OPC_HALT);
  assign cls.is_illegal = !(cls.is_alu || cls.is_nop || cls.is_halt);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_oh
    assign ra_oh[i] = (ra == REG_IDX_W'(i));
    assign rb_oh[i] = (rb == REG_IDX_W'(i));
    assign rc_oh[i] = (rc == REG_IDX_W'(i));
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute FSM driving the bus datapath.
// Optional macro CTRL_ILLEGAL_TRAP_EN: trap unknown opcodes to FAULT instead of NOP.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int OPC_W       = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                Clock,
  input  logic                clr,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [IR_W-1:0]     IR,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                PCin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                MARin,
  output logic                MDRin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OPC_W-1:0]    ALU_select,
  output logic                halted,
  output logic                fault
);

  state_t              state, state_n;
  logic [3:0]          wait_cnt, wait_inc;
  op_class_t           cls;
  logic [4:0]          opc;
  logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
  logic                unused_cls;

  ir_decoder #(.NUM_REGS(NUM_REGS)) u_dec (
    .IR    (IR),
    .cls   (cls),
    .opc   (opc),
    .ra_oh (ra_oh),
    .rb_oh (rb_oh),
    .rc_oh (rc_oh)
  );

  assign unused_cls = cls.is_nop | cls.is_illegal;
  assign wait_inc   = wait_cnt + 4'd1;

  always_ff @(posedge Clock or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= (state == S_T1 && !mem_ready) ? wait_inc : '0;
      if (state_n == S_HALT)  halted <= 1'b1;
      if (state_n == S_FAULT) fault  <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    PCin       = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Rin        = '0;
    Rout       = '0;
    ALU_select = OPC_W'(ALU_SEL_NONE);
    case (state)
      S_IDLE: if (run) state_n = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_n = S_T1;
      end
      S_T1: begin
        // strobes held while waiting; reloading PC from unchanged Z is harmless
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (mem_ready)                              state_n = S_T2;
        else if (wait_inc == 4'(MEM_TIMEOUT))       state_n = S_FAULT;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_n = S_T3;
      end
      S_T3: begin
        // first cycle the new IR is visible: doubles as the decode cycle
        if (cls.is_alu) begin
          Rout    = rb_oh;
          Yin     = 1'b1;
          state_n = S_T4;
        end else if (cls.is_halt) begin
          state_n = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
        end else if (cls.is_illegal) begin
          state_n = S_FAULT;
`endif
        end else begin
          state_n = run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        Rout = rc_oh; Zin = 1'b1; ALU_select = OPC_W'(opc);
        state_n = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1; Rin = ra_oh;
        state_n = run ? S_T0 : S_IDLE;
      end
      S_HALT, S_FAULT: state_n = state;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer: per-instruction
// expected strobe traces built from the instruction-level rules.
module tb_control_sequencer;

  typedef logic [49:0] ovec_t;
  localparam ovec_t O_HALTED = ovec_t'(1) << 49;
  localparam ovec_t O_FAULT  = ovec_t'(1) << 48;
  localparam ovec_t O_PCOUT  = ovec_t'(1) << 47;
  localparam ovec_t O_ZLO    = ovec_t'(1) << 46;
  localparam ovec_t O_MDRO   = ovec_t'(1) << 45;
  localparam ovec_t O_PCIN   = ovec_t'(1) << 44;
  localparam ovec_t O_IRIN   = ovec_t'(1) << 43;
  localparam ovec_t O_YIN    = ovec_t'(1) << 42;
  localparam ovec_t O_ZIN    = ovec_t'(1) << 41;
  localparam ovec_t O_MARIN  = ovec_t'(1) << 40;
  localparam ovec_t O_MDRIN  = ovec_t'(1) << 39;
  localparam ovec_t O_INCPC  = ovec_t'(1) << 38;
  localparam ovec_t O_READ   = ovec_t'(1) << 37;
  localparam ovec_t V_T0 = O_PCOUT | O_MARIN | O_INCPC | O_ZIN;
  localparam ovec_t V_T1 = O_ZLO | O_PCIN | O_READ | O_MDRIN;
  localparam ovec_t V_T2 = O_MDRO | O_IRIN;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        Clock = 1'b0, clr = 1'b1, run = 1'b0, mem_ready = 1'b0;
  logic [31:0] IR = '0, mem_data = '0;
  logic PCout, Zlowout, MDRout, PCin, IRin, Yin, Zin, MARin, MDRin, IncPC, Read;
  logic [15:0] Rin, Rout;
  logic [4:0]  ALU_select;
  logic        halted, fault;
  ovec_t       obs;

  int n_chk = 0, n_fail = 0;

  ovec_t exp_q[$];
  bit    rdy_q[$], run_q[$];
  string tag_q[$];

  control_sequencer dut (
    .Clock(Clock), .clr(clr), .run(run), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .PCin(PCin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin), .IncPC(IncPC), .Read(Read),
    .Rin(Rin), .Rout(Rout), .ALU_select(ALU_select), .halted(halted), .fault(fault)
  );

  always #5 Clock = ~Clock;

  // IR register of the datapath: loaded from memory data when IRin strobes
  always @(posedge Clock) if (IRin) IR <= mem_data;

  assign obs = {halted, fault, PCout, Zlowout, MDRout, PCin, IRin, Yin, Zin,
                MARin, MDRin, IncPC, Read, ALU_select, Rin, Rout};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit coin();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ovec_t bit_at(int pos);
    return ovec_t'(1) << pos;
  endfunction

  function automatic logic [31:0] mk(int opc, int ra, int rb, int rc);
    logic [14:0] lo;
    lo = 15'($urandom);
    return {5'(opc), 4'(ra), 4'(rb), 4'(rc), lo};
  endfunction

  task automatic push(input ovec_t v, input bit rdy, input bit r, input string t);
    exp_q.push_back(v); rdy_q.push_back(rdy); run_q.push_back(r); tag_q.push_back(t);
  endtask

  // clr asserted mid-cycle must blank everything at once; run=1 restarts at T0
  task automatic do_clr();
    @(negedge Clock);
    clr = 1'b1; run = coin();
    #1 check("clr_same_cycle", 64'(obs), 64'(0));
    @(negedge Clock);
    clr = 1'b0; run = 1'b1;
    #1 check("idle_after_clr", 64'(obs), 64'(0));
  endtask

  // Instruction starts at T0 (run was 1 at the previous boundary)
  task automatic run_instr(input logic [31:0] instr, input int waits,
                           input bit drop, input bit abort);
    int opc, ra, rb, rc;
    bit alu, nop, hlt, ill, need_clr;
    opc = int'(instr[31:27]); ra = int'(instr[26:23]);
    rb  = int'(instr[22:19]); rc = int'(instr[18:15]);
    alu = (opc >= 3) && (opc <= 10);
    nop = (opc == 26);
    hlt = (opc == 27);
    ill = !(alu || nop || hlt);
    need_clr = 1'b0;
    exp_q.delete(); rdy_q.delete(); run_q.delete(); tag_q.delete();
    mem_data = instr;

    push(V_T0, coin(), coin(), "T0");
    for (int j = 0; j < 15 && j <= waits; j++) push(V_T1, j == waits, coin(), "T1");
    if (waits >= 15) begin
      repeat (3) push(O_FAULT, coin(), coin(), "timeout_fault");
      need_clr = 1'b1;
    end else begin
      push(V_T2, coin(), coin(), "T2");
      if (alu) begin
        push(bit_at(rb) | O_YIN, coin(), coin(), "T3");
        if (abort) need_clr = 1'b1;
        else begin
          push(bit_at(rc) | O_ZIN | (ovec_t'(opc) << 32), coin(), drop ? 1'b0 : coin(), "T4");
          push(O_ZLO | bit_at(16 + ra), coin(), !drop, "T5");
        end
      end else if (hlt) begin
        push('0, coin(), coin(), "halt_decode");
        repeat (3) push(O_HALTED, coin(), 1'b1, "HALT");
        need_clr = 1'b1;
      end else if (ill && TRAP) begin
        push('0, coin(), coin(), "trap_decode");
        repeat (3) push(O_FAULT, coin(), coin(), "trap_fault");
        need_clr = 1'b1;
      end else begin
        push('0, coin(), !drop, nop ? "nop_decode" : "illegal_nop");
      end
      if (drop && !need_clr) begin
        push('0, coin(), 1'b0, "IDLE");
        push('0, coin(), 1'b1, "IDLE");
      end
    end

    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      mem_ready = rdy_q[i];
      run       = run_q[i];
      #1 check(tag_q[i], 64'(obs), 64'(exp_q[i]));
    end
    if (need_clr) do_clr();
  endtask

  initial begin
    int sel, o, w;
    #1 check("reset_state", 64'(obs), 64'(0));
    @(negedge Clock);
    clr = 1'b0;
    #1 check("idle_run0", 64'(obs), 64'(0));
    @(negedge Clock);
    #1 check("idle_run0_hold", 64'(obs), 64'(0));
    run = 1'b1;

    run_instr(32'h4A920000, 0, 1'b0, 1'b0);   // R5 <- R2 op R4
    run_instr(mk(3, 3, 3, 3), 3, 1'b0, 1'b0); // add R3,R3,R3 after 3 wait cycles
    run_instr(mk(10, 15, 0, 7), 14, 1'b0, 1'b0); // ready in the limit cycle
    run_instr(mk(5, 1, 2, 3), 0, 1'b0, 1'b1);  // clr during T4
    run_instr(mk(4, 1, 1, 1), 15, 1'b0, 1'b0); // memory timeout
    run_instr(32'hD8000000, 0, 1'b0, 1'b0);    // HALT
    run_instr(mk(31, 2, 3, 4), 1, 1'b0, 1'b0); // illegal 11111
    run_instr(mk(26, 0, 0, 0), 0, 1'b1, 1'b0); // NOP, run dropped
    run_instr(mk(7, 9, 8, 6), 2, 1'b1, 1'b0);  // run dropped in T4

    for (int n = 0; n < 160; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      o = int'($urandom_range(3, 10));
      else if (sel == 6) o = 26;
      else if (sel == 7) o = 27;
      else if (sel == 8) begin
        do o = int'($urandom_range(0, 31));
        while ((o >= 3 && o <= 10) || o == 26 || o == 27);
      end else o = int'($urandom_range(0, 31));
      w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 15)) : int'($urandom_range(0, 3));
      run_instr(mk(o, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15))),
                w, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
